bus_datapath_core: RTL and testbench

Parametrised single-bus CPU datapath: general register file, PC/IR/MAR/MDR, HI/LO, Y/Z, in/out ports and an ALU, all sharing one internal bus selected by an encoded source code. It generalises the fixed 32-bit, 16-register datapath in data width and register count, and adds two things: a handshaked memory interface with wait states, and iterative multi-cycle multiply/divide. It sits between the control unit (which drives every strobe below) and external memory/IO.

---
 rtl/bus_datapath_pkg.sv | 33 +++
 rtl/bus_datapath_muldiv_seq.sv | 106 ++++++++++
 rtl/bus_datapath_core.sv | 223 ++++++++++++++++++++++
 tb/tb_bus_datapath_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_datapath_pkg.sv
// Shared codes for the single-bus datapath: ALU opcodes, bus source selects
// and the memory handshake state encoding.
package bus_datapath_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_NEG  = 4'd9;
  localparam logic [3:0] ALU_NOT  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;

  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/bus_datapath_muldiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) on magnitudes,
// one bit per cycle. Only built when BUS_DATAPATH_MULDIV_EN is defined.
`ifdef BUS_DATAPATH_MULDIV_EN
module muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_last,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  localparam int CNT_W = $clog2(DATA_W);

  logic                r_busy, r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc, r_q, r_m, r_dividend;
  logic [DATA_W:0]     w_sum, w_rsh, w_diff;
  logic [DATA_W-1:0]   w_addend, w_acc_n, w_q_n, w_a_mag, w_b_mag, w_quo, w_rem;
  logic [2*DATA_W-1:0] w_prod, w_prod_s;

  assign w_a_mag = i_a[DATA_W-1] ? -i_a : i_a;
  assign w_b_mag = i_b[DATA_W-1] ? -i_b : i_b;

  // One iteration: r_acc is the running high half (mul) or partial remainder (div).
  always_comb begin
    w_addend = r_q[0] ? r_m : {DATA_W{1'b0}};
    w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    w_rsh    = {r_acc, r_q[DATA_W-1]};
    w_diff   = w_rsh - {1'b0, r_m};
    if (r_is_div) begin
      if (!w_diff[DATA_W]) begin
        w_acc_n = w_diff[DATA_W-1:0];
        w_q_n   = {r_q[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_n = w_rsh[DATA_W-1:0];
        w_q_n   = {r_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_n = w_sum[DATA_W:1];
      w_q_n   = {w_sum[0], r_q[DATA_W-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's values so Z can load on the last busy edge.
  always_comb begin
    w_prod   = {w_acc_n, w_q_n};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -w_q_n : w_q_n;
    w_rem    = r_neg_r ? -w_acc_n : w_acc_n;
    if (!r_is_div) begin
      o_hi = w_prod_s[2*DATA_W-1:DATA_W];
      o_lo = w_prod_s[DATA_W-1:0];
    end else if (r_dz) begin
      o_hi = r_dividend;
      o_lo = {DATA_W{1'b1}};
    end else begin
      o_hi = w_rem;
      o_lo = w_quo;
    end
  end

  // Operand capture on start, then exactly DATA_W iterations.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_busy     <= 1'b0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_dividend <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy     <= 1'b1;
        r_cnt      <= '0;
        r_is_div   <= i_is_div;
        r_acc      <= '0;
        r_dividend <= i_a;
        r_dz       <= i_is_div && (i_b == '0);
        r_neg_q    <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
        r_neg_r    <= i_a[DATA_W-1];
        r_q        <= i_is_div ? w_a_mag : w_b_mag;
        r_m        <= i_is_div ? w_b_mag : w_a_mag;
      end
    end else begin
      r_acc <= w_acc_n;
      r_q   <= w_q_n;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_last) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_last = r_busy && (r_cnt == CNT_W'(DATA_W - 1));

endmodule
`endif

// File: rtl/bus_datapath_core.sv
// Single-bus CPU datapath with handshaked memory port and ALU.
// Define BUS_DATAPATH_MULDIV_EN for iterative MUL/DIV; otherwise ops 11/12 yield 0.
module bus_datapath_core
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 9,
  parameter int IMM_W    = 19
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [4:0]          bus_src,
  input  logic                ba_out,
  input  logic [NUM_REGS-1:0] reg_we,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                y_in,
  input  logic                pc_in,
  input  logic                inc_pc,
  input  logic                ir_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                outport_in,
  input  logic [3:0]          alu_op,
  input  logic                alu_go,
  output logic                alu_busy,
  input  logic                mem_rd,
  input  logic                mem_wr,
  output logic                mem_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   inport_data,
  input  logic                inport_strobe,
  output logic [DATA_W-1:0]   outport_data,
  output logic [DATA_W-1:0]   ir_q,
  output logic [DATA_W-1:0]   bus_q
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_hi, r_lo, r_y, r_zhi, r_zlo, r_pc, r_ir, r_mdr;
  logic [DATA_W-1:0] r_inport, r_outport, r_mem_wdata;
  logic [ADDR_W-1:0] r_mar, r_mem_addr;
  logic              r_mem_req, r_mem_we;
  mem_state_e        r_mem_state;

  logic [DATA_W-1:0] w_bus, w_csign, w_alu_res;
  logic [SH_W-1:0]   w_sh;
  logic              w_alu_busy, w_alu_start;

  assign w_csign = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
  assign w_sh    = w_bus[SH_W-1:0];

  // Bus source mux.
  always_comb begin
    w_bus = '0;
    if (bus_src < 5'(NUM_REGS)) begin
      if (ba_out && (bus_src == 5'd0)) w_bus = '0;
      else                             w_bus = r_regs[bus_src[3:0]];
    end else begin
      case (bus_src)
        SRC_HI:     w_bus = r_hi;
        SRC_LO:     w_bus = r_lo;
        SRC_ZHI:    w_bus = r_zhi;
        SRC_ZLO:    w_bus = r_zlo;
        SRC_PC:     w_bus = r_pc;
        SRC_MDR:    w_bus = r_mdr;
        SRC_INPORT: w_bus = r_inport;
        SRC_CSIGN:  w_bus = w_csign;
        default:    w_bus = '0;
      endcase
    end
  end

  // Single-cycle ALU: A = Y, B = bus; MUL/DIV and spare codes fall to 0 here.
  always_comb begin
    w_alu_res = '0;
    case (alu_op)
      ALU_ADD:  w_alu_res = r_y + w_bus;
      ALU_SUB:  w_alu_res = r_y - w_bus;
      ALU_AND:  w_alu_res = r_y & w_bus;
      ALU_OR:   w_alu_res = r_y | w_bus;
      ALU_SHR:  w_alu_res = r_y >> w_sh;
      ALU_SHRA: w_alu_res = $signed(r_y) >>> w_sh;
      ALU_SHL:  w_alu_res = r_y << w_sh;
      ALU_ROR:  w_alu_res = (r_y >> w_sh) | (r_y << (DATA_W - int'(w_sh)));
      ALU_ROL:  w_alu_res = (r_y << w_sh) | (r_y >> (DATA_W - int'(w_sh)));
      ALU_NEG:  w_alu_res = -w_bus;
      ALU_NOT:  w_alu_res = ~w_bus;
      default:  w_alu_res = '0;
    endcase
  end

  assign w_alu_start = alu_go && !w_alu_busy;

`ifdef BUS_DATAPATH_MULDIV_EN
  logic              w_md_op, w_md_last;
  logic [DATA_W-1:0] w_md_hi, w_md_lo;

  assign w_md_op = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);

  muldiv_seq #(.DATA_W(DATA_W)) u_muldiv (
    .i_clk    (clock),
    .i_clear  (clear),
    .i_start  (w_alu_start && w_md_op),
    .i_is_div (alu_op == ALU_DIV),
    .i_a      (r_y),
    .i_b      (w_bus),
    .o_busy   (w_alu_busy),
    .o_last   (w_md_last),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  // Z register: iterative result lands on the last busy edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_zhi <= '0;
      r_zlo <= '0;
    end else if (w_md_last) begin
      r_zhi <= w_md_hi;
      r_zlo <= w_md_lo;
    end else if (w_alu_start && !w_md_op) begin
      r_zhi <= '0;
      r_zlo <= w_alu_res;
    end
  end
`else
  assign w_alu_busy = 1'b0;

  // Z register: every op completes in one cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_zhi <= '0;
      r_zlo <= '0;
    end else if (w_alu_start) begin
      r_zhi <= '0;
      r_zlo <= w_alu_res;
    end
  end
`endif

  // Register file and bus-loaded special registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_y       <= '0;
      r_pc      <= '0;
      r_ir      <= '0;
      r_mar     <= '0;
      r_inport  <= '0;
      r_outport <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) r_regs[i] <= w_bus;
      end
      if (hi_in)         r_hi      <= w_bus;
      if (lo_in)         r_lo      <= w_bus;
      if (y_in)          r_y       <= w_bus;
      if (ir_in)         r_ir      <= w_bus;
      if (mar_in)        r_mar     <= w_bus[ADDR_W-1:0];
      if (inport_strobe) r_inport  <= inport_data;
      if (outport_in)    r_outport <= w_bus;
      if (pc_in)         r_pc      <= w_bus;
      else if (inc_pc)   r_pc      <= r_pc + DATA_W'(1);
    end
  end

  // Memory handshake FSM; owns MDR so a read return and mdr_in never collide.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_mem_state <= MEM_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mdr       <= '0;
    end else begin
      case (r_mem_state)
        MEM_IDLE: begin
          if (mem_rd || mem_wr) begin
            r_mem_state <= MEM_REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_wr;
            r_mem_addr  <= r_mar;
            r_mem_wdata <= r_mdr;
          end
          if (mdr_in) r_mdr <= w_bus;
        end
        MEM_REQ: begin
          if (mem_ack) begin
            r_mem_state <= MEM_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            if (!r_mem_we) r_mdr <= mem_rdata;
          end
        end
        default: begin
          r_mem_state <= MEM_IDLE;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_busy     = (r_mem_state != MEM_IDLE);
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign alu_busy     = w_alu_busy;
  assign outport_data = r_outport;
  assign ir_q         = r_ir;
  assign bus_q        = w_bus;

endmodule

// File: tb/tb_bus_datapath_core.sv
// Directed self-checking bench for bus_datapath_core (default parameters).
// MUL/DIV expectations follow BUS_DATAPATH_MULDIV_EN.
module tb_bus_datapath_core;
  import bus_datapath_pkg::*;

  logic        clock = 1'b0;
  logic        clear, ba_out, hi_in, lo_in, y_in, pc_in, inc_pc, ir_in, mar_in, mdr_in, outport_in;
  logic [4:0]  bus_src;
  logic [15:0] reg_we;
  logic [3:0]  alu_op;
  logic        alu_go, alu_busy, mem_rd, mem_wr, mem_busy, mem_req, mem_we, mem_ack, inport_strobe;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, inport_data, outport_data, ir_q, bus_q;

  int checks   = 0;
  int failures = 0;
  int n_busy;

  bus_datapath_core dut (
    .clock(clock), .clear(clear), .bus_src(bus_src), .ba_out(ba_out), .reg_we(reg_we),
    .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .pc_in(pc_in), .inc_pc(inc_pc),
    .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in),
    .alu_op(alu_op), .alu_go(alu_go), .alu_busy(alu_busy),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_busy(mem_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inport_data(inport_data), .inport_strobe(inport_strobe), .outport_data(outport_data),
    .ir_q(ir_q), .bus_q(bus_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_src(input string tag, input logic [4:0] s, input logic [31:0] exp);
    bus_src = s;
    #1;
    check(tag, {32'h0, bus_q}, {32'h0, exp});
  endtask

  task automatic put(input logic [31:0] v);
    inport_data   = v;
    inport_strobe = 1'b1;
    tick();
    inport_strobe = 1'b0;
    bus_src       = SRC_INPORT;
  endtask

  task automatic alu(input logic [3:0] op, input logic [4:0] s);
    bus_src = s;
    alu_op  = op;
    alu_go  = 1'b1;
    tick();
    alu_go  = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (alu_busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    clear = 1'b1; ba_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0; y_in = 1'b0; pc_in = 1'b0;
    inc_pc = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; outport_in = 1'b0;
    bus_src = 5'd0; reg_we = 16'h0; alu_op = 4'd0; alu_go = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; inport_data = 32'h0; inport_strobe = 1'b0;
    tick();
    clear = 1'b0;
    check("rst_alu_busy", {63'h0, alu_busy}, 64'h0);
    check("rst_mem_req", {63'h0, mem_req}, 64'h0);
    check("rst_mem_busy", {63'h0, mem_busy}, 64'h0);
    check("rst_outport", {32'h0, outport_data}, 64'h0);
    check("rst_ir", {32'h0, ir_q}, 64'h0);
    check_src("rst_zlo", SRC_ZLO, 32'h0);
    check_src("rst_zhi", SRC_ZHI, 32'h0);
    check_src("rst_mdr", SRC_MDR, 32'h0);
    check_src("rst_pc", SRC_PC, 32'h0);

    // Register transfers and ADD
    put(32'h14); reg_we = 16'h0004; tick(); reg_we = 16'h0;
    put(32'h22); reg_we = 16'h0008; tick(); reg_we = 16'h0;
    check_src("r2", 5'd2, 32'h14);
    check_src("r3", 5'd3, 32'h22);
    bus_src = 5'd2; y_in = 1'b1; tick(); y_in = 1'b0;
    alu(ALU_ADD, 5'd3);
    check_src("add_zlo", SRC_ZLO, 32'h36);
    check_src("add_zhi", SRC_ZHI, 32'h0);
    put(32'h7); reg_we = 16'h0001; tick(); reg_we = 16'h0;
    ba_out = 1'b1;
    check_src("ba_out_r0", 5'd0, 32'h0);
    ba_out = 1'b0;
    check_src("r0", 5'd0, 32'h7);

    // More single-cycle ops with Y = 0x14
    alu(ALU_SUB, 5'd3);
    check_src("sub_zlo", SRC_ZLO, 32'hFFFFFFF2);
    alu(4'd13, 5'd3);
    check_src("op13_zlo", SRC_ZLO, 32'h0);
    alu(ALU_SHL, 5'd0);
    check_src("shl_zlo", SRC_ZLO, 32'h00000A00);
    alu(ALU_ROR, 5'd0);
    check_src("ror_zlo", SRC_ZLO, 32'h28000000);

    // PC, outport, IR / CSIGN
    inc_pc = 1'b1; tick(); inc_pc = 1'b0;
    check_src("pc_inc", SRC_PC, 32'h1);
    bus_src = 5'd3; pc_in = 1'b1; inc_pc = 1'b1; tick(); pc_in = 1'b0; inc_pc = 1'b0;
    check_src("pc_load_wins", SRC_PC, 32'h22);
    bus_src = 5'd3; outport_in = 1'b1; tick(); outport_in = 1'b0;
    check("outport", {32'h0, outport_data}, 64'h22);
    put(32'h000400F0); ir_in = 1'b1; tick(); ir_in = 1'b0;
    check("ir_q", {32'h0, ir_q}, 64'h000400F0);
    check_src("csign", SRC_CSIGN, 32'hFFFC00F0);

    // Memory read with three wait states; mdr_in while busy must be ignored
    put(32'h1F); mar_in = 1'b1; tick(); mar_in = 1'b0;
    mem_rd = 1'b1; tick(); mem_rd = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("rd_busy", {63'h0, mem_busy}, 64'h1);
      check("rd_req", {63'h0, mem_req}, 64'h1);
      check("rd_we", {63'h0, mem_we}, 64'h0);
      check("rd_addr", {55'h0, mem_addr}, 64'h1F);
      if (i == 3) check_src("rd_mdr_hold", SRC_MDR, 32'h0);
      bus_src   = SRC_INPORT;
      mdr_in    = (i == 2);
      mem_ack   = (i == 4);
      mem_rdata = (i == 4) ? 32'hDEADBEEF : 32'h0;
      tick();
    end
    mem_ack = 1'b0; mdr_in = 1'b0;
    check("rd_done_busy", {63'h0, mem_busy}, 64'h0);
    check("rd_done_req", {63'h0, mem_req}, 64'h0);
    check_src("rd_mdr", SRC_MDR, 32'hDEADBEEF);

    // Zero-wait write; write wins over simultaneous read
    put(32'hA5); mdr_in = 1'b1; tick(); mdr_in = 1'b0;
    check_src("mdr_load", SRC_MDR, 32'hA5);
    mem_wr = 1'b1; mem_rd = 1'b1; tick(); mem_wr = 1'b0; mem_rd = 1'b0;
    check("wr_req", {63'h0, mem_req}, 64'h1);
    check("wr_we", {63'h0, mem_we}, 64'h1);
    check("wr_wdata", {32'h0, mem_wdata}, 64'hA5);
    mem_ack = 1'b1; mem_rdata = 32'h12345678; tick(); mem_ack = 1'b0;
    check("wr_done_busy", {63'h0, mem_busy}, 64'h0);
    check_src("wr_mdr_kept", SRC_MDR, 32'hA5);

    // Clear in the middle of a memory access
    mem_rd = 1'b1; tick(); mem_rd = 1'b0;
    check("mid_rd_req", {63'h0, mem_req}, 64'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_mem_req", {63'h0, mem_req}, 64'h0);
    check("clr_mem_busy", {63'h0, mem_busy}, 64'h0);
    check_src("clr_mdr", SRC_MDR, 32'h0);

    // MUL -3 * 7
    put(32'hFFFFFFFD); y_in = 1'b1; tick(); y_in = 1'b0;
    put(32'h7);
    bus_src = 5'd3; alu(ALU_ADD, SRC_INPORT);
    check_src("pre_mul_zlo", SRC_ZLO, 32'h4);
    alu(ALU_MUL, SRC_INPORT);
`ifdef BUS_DATAPATH_MULDIV_EN
    run_busy(n_busy);
    check("mul_cycles", 64'(n_busy), 64'd32);
    check_src("mul_zhi", SRC_ZHI, 32'hFFFFFFFF);
    check_src("mul_zlo", SRC_ZLO, 32'hFFFFFFEB);
`else
    check("mul_busy", {63'h0, alu_busy}, 64'h0);
    check_src("mul_zlo", SRC_ZLO, 32'h0);
    check_src("mul_zhi", SRC_ZHI, 32'h0);
`endif

    // DIV 17 / -5 and 9 / 0
    put(32'd17); y_in = 1'b1; tick(); y_in = 1'b0;
    put(32'hFFFFFFFB);
    alu(ALU_DIV, SRC_INPORT);
`ifdef BUS_DATAPATH_MULDIV_EN
    run_busy(n_busy);
    check("div_cycles", 64'(n_busy), 64'd32);
    check_src("div_zlo", SRC_ZLO, 32'hFFFFFFFD);
    check_src("div_zhi", SRC_ZHI, 32'h2);
`else
    check_src("div_zlo", SRC_ZLO, 32'h0);
`endif
    put(32'd9); y_in = 1'b1; tick(); y_in = 1'b0;
    put(32'h0);
    alu(ALU_DIV, SRC_INPORT);
`ifdef BUS_DATAPATH_MULDIV_EN
    run_busy(n_busy);
    check_src("div0_zlo", SRC_ZLO, 32'hFFFFFFFF);
    check_src("div0_zhi", SRC_ZHI, 32'h9);
`else
    check_src("div0_zhi", SRC_ZHI, 32'h0);
`endif

    // Clear during the 10th MUL busy cycle, then a fresh MUL 6 * 7
    put(32'd6); y_in = 1'b1; tick(); y_in = 1'b0;
    put(32'h7);
    alu(ALU_ADD, SRC_INPORT);
    alu(ALU_MUL, SRC_INPORT);
    repeat (9) tick();
`ifdef BUS_DATAPATH_MULDIV_EN
    check("mul_mid_busy", {63'h0, alu_busy}, 64'h1);
    check_src("mul_mid_zlo", SRC_ZLO, 32'hD);
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_alu_busy", {63'h0, alu_busy}, 64'h0);
    check_src("clr_zlo", SRC_ZLO, 32'h0);
    check_src("clr_zhi", SRC_ZHI, 32'h0);
    check_src("clr_r3", 5'd3, 32'h0);
    put(32'd6); y_in = 1'b1; tick(); y_in = 1'b0;
    put(32'h7);
    alu(ALU_MUL, SRC_INPORT);
`ifdef BUS_DATAPATH_MULDIV_EN
    run_busy(n_busy);
    check("mul2_cycles", 64'(n_busy), 64'd32);
    check_src("mul2_zlo", SRC_ZLO, 32'h2A);
    check_src("mul2_zhi", SRC_ZHI, 32'h0);
`else
    check("mul2_busy", {63'h0, alu_busy}, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
